// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader and the instruction
// memory's word assembly: word/byte geometry and the loader state encoding.
package instruction_memory_loader_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;
  localparam int BYTE_IDX_WIDTH = $clog2(BYTES_PER_WORD);

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [BYTE_WIDTH-1:0]     byte_t;
  typedef logic [BYTE_IDX_WIDTH-1:0] byte_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Most significant byte of a word: the first byte written (big-endian order).
  function automatic byte_t msb_byte(input word_t w);
    return w[WORD_WIDTH-1 -: BYTE_WIDTH];
  endfunction

endpackage : instruction_memory_loader_pkg

// File: rtl/instruction_memory_loader_if.sv
// Word stream in, byte write port out, plus load status. The source side uses
// the master modport, the loader the slave modport.
interface instruction_memory_loader_if
  import instruction_memory_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
);

  // Word stream from the boot/test-load source
  logic                  word_valid;
  word_t                 word_data;
  logic                  word_last;
  logic                  word_ready;

  // Byte write port towards the instruction memory
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  byte_t                 mem_wdata;

  // Load status
  logic                  done;
  logic [ADDR_WIDTH-2:0] word_count;

  modport master (
    output word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, done, word_count
  );

  modport slave (
    input  word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, done, word_count
  );

endinterface : instruction_memory_loader_if

// File: rtl/instruction_memory_loader.sv
// Serialises 32-bit instruction words into four big-endian byte writes.
// Every output is taken straight from a register so the byte write port and
// the handshake carry no combinational path from the inputs.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        rst,    // asynchronous, active-low
  input  logic                        clear,  // synchronous abort and restart
  instruction_memory_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-2:0] COUNT_ONE = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};
  localparam byte_idx_t             LAST_IDX  = byte_idx_t'(BYTES_PER_WORD - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next;
  word_t                 shift, shift_next;
  byte_idx_t             byte_idx, byte_idx_next;
  logic                  last_q, last_next;
  logic [ADDR_WIDTH-2:0] count, count_next;
  logic                  ready_q, ready_next;

  logic [ADDR_WIDTH-1:0] ptr_inc;
  logic                  transfer;

  assign ptr_inc  = ptr + PTR_ONE;
  assign transfer = bus.word_valid && ready_q;

  // Next-state and datapath update: clear overrides every transition.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
    state_next    = state;
    ptr_next      = ptr;
    shift_next    = shift;
    byte_idx_next = byte_idx;
    last_next     = last_q;
    count_next    = count;

    if (clear) begin
      state_next    = ST_IDLE;
      ptr_next      = BASE_ADDR;
      byte_idx_next = '0;
      count_next    = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (transfer) begin
            shift_next    = bus.word_data;
            last_next     = bus.word_last;
            byte_idx_next = '0;
            state_next    = ST_WRITE;
          end
        end

        ST_WRITE: begin
          ptr_next      = ptr_inc;
          shift_next    = shift << BYTE_WIDTH;
          byte_idx_next = byte_idx + 1'b1;
          if (byte_idx == LAST_IDX) begin
            count_next = count + COUNT_ONE;
            // A wrapped pointer means the top byte was just written: memory full.
            state_next = (last_q || (ptr_inc == '0)) ? ST_DONE : ST_IDLE;
          end
        end

        ST_DONE: begin
          state_next = ST_DONE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    // Ready is registered so it depends only on state, and stays low in reset.
    ready_next = (state_next == ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: pointer, shift register, byte index, counters.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the shift register is reset too, because mem_wdata is read straight from it and must be 0 in reset.
    if (!rst) begin
      ptr      <= BASE_ADDR;
      shift    <= '0;
      byte_idx <= '0;
      last_q   <= 1'b0;
      count    <= '0;
      ready_q  <= 1'b0;
    end else begin
      ptr      <= ptr_next;
      shift    <= shift_next;
      byte_idx <= byte_idx_next;
      last_q   <= last_next;
      count    <= count_next;
      ready_q  <= ready_next;
    end
  end

  assign bus.word_ready = ready_q;
  assign bus.mem_we     = (state == ST_WRITE);
  assign bus.mem_addr   = ptr;
  assign bus.mem_wdata  = msb_byte(shift);
  assign bus.done       = (state == ST_DONE);
  assign bus.word_count = count;

`ifndef SYNTHESIS
  // A word is never accepted while its predecessor is still being written.
  assert property (@(posedge clk) disable iff (!rst) bus.mem_we |-> !bus.word_ready);
  // Nothing is written once the image is complete.
  assert property (@(posedge clk) disable iff (!rst) bus.done |-> !bus.mem_we);
`endif

endmodule : instruction_memory_loader

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: three instances cover the
// default configuration, a 16-byte memory that fills up, and a non-zero base.
module tb_instruction_memory_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, clear_a, rst_o, clear_o;

  instruction_memory_loader_if #(.ADDR_WIDTH(16)) bus_a ();
  instruction_memory_loader_if #(.ADDR_WIDTH(4))  bus_f ();
  instruction_memory_loader_if #(.ADDR_WIDTH(16)) bus_b ();

  instruction_memory_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'h0000)) dut_a (
    .clk(clk), .rst(rst_a), .clear(clear_a), .bus(bus_a.slave));
  instruction_memory_loader #(.ADDR_WIDTH(4), .BASE_ADDR(4'h0)) dut_f (
    .clk(clk), .rst(rst_o), .clear(clear_o), .bus(bus_f.slave));
  instruction_memory_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'h0100)) dut_b (
    .clk(clk), .rst(rst_o), .clear(clear_o), .bus(bus_b.slave));

  // Byte memories written by the loaders, plus write counters.
  logic [7:0] mem_a [65536];
  logic [7:0] mem_f [16];
  logic [7:0] mem_b [65536];
  int wr_a = 0;
  int wr_f = 0;
  int wr_b = 0;

  always @(posedge clk) begin
    if (bus_a.mem_we) begin mem_a[bus_a.mem_addr] <= bus_a.mem_wdata; wr_a <= wr_a + 1; end
    if (bus_f.mem_we) begin mem_f[bus_f.mem_addr] <= bus_f.mem_wdata; wr_f <= wr_f + 1; end
    if (bus_b.mem_we) begin mem_b[bus_b.mem_addr] <= bus_b.mem_wdata; wr_b <= wr_b + 1; end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a(input string tag);
    int n = 0;
    while (!bus_a.word_ready && n < 20) begin tick(); n++; end
    check(tag, 32'(bus_a.word_ready), 32'd1);
  endtask

  // Checks four consecutive byte writes starting in the current cycle.
  task automatic expect_bytes_a(input string tag, input logic [15:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_we%0d", tag, i),   32'(bus_a.mem_we),    32'd1);
      check($sformatf("%s_addr%0d", tag, i), 32'(bus_a.mem_addr), 32'(addr + 16'(i)));
      check($sformatf("%s_data%0d", tag, i), 32'(bus_a.mem_wdata), 32'(w[31-8*i -: 8]));
      tick();
    end
  endtask

  logic [31:0] words_f [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr0;
    int n;
    rst_a = 1'b0; rst_o = 1'b0; clear_a = 1'b0; clear_o = 1'b0;
    bus_a.word_valid = 1'b0; bus_a.word_data = '0; bus_a.word_last = 1'b0;
    bus_f.word_valid = 1'b0; bus_f.word_data = '0; bus_f.word_last = 1'b0;
    bus_b.word_valid = 1'b0; bus_b.word_data = '0; bus_b.word_last = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_we",    32'(bus_a.mem_we),     32'd0);
    check("rst_addr",  32'(bus_a.mem_addr),   32'd0);
    check("rst_wdata", 32'(bus_a.mem_wdata),  32'd0);
    check("rst_ready", 32'(bus_a.word_ready), 32'd0);
    check("rst_done",  32'(bus_a.done),       32'd0);
    check("rst_count", 32'(bus_a.word_count), 32'd0);
    check("rst_addr_base", 32'(bus_b.mem_addr), 32'h100);

    rst_a = 1'b1; rst_o = 1'b1;
    tick(); tick();

    // Single word, last=1
    bus_a.word_valid = 1'b1; bus_a.word_data = 32'h12345678; bus_a.word_last = 1'b1;
    wait_ready_a("single_ready");
    tick();
    bus_a.word_valid = 1'b0;
    expect_bytes_a("single", 16'h0000, 32'h12345678);
    check("single_done",  32'(bus_a.done),       32'd1);
    check("single_count", 32'(bus_a.word_count), 32'd1);
    check("single_ready_low", 32'(bus_a.word_ready), 32'd0);
    check("single_we_low", 32'(bus_a.mem_we),    32'd0);
    check("single_mem3",  32'(mem_a[3]),         32'h78);

    // Back-to-back with valid held
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    check("clr_done",  32'(bus_a.done),       32'd0);
    check("clr_count", 32'(bus_a.word_count), 32'd0);
    check("clr_ready", 32'(bus_a.word_ready), 32'd1);
    bus_a.word_valid = 1'b1; bus_a.word_data = 32'hAABBCCDD; bus_a.word_last = 1'b0;
    tick();
    bus_a.word_data = 32'h01020304; bus_a.word_last = 1'b1;
    expect_bytes_a("b2b_w0", 16'h0000, 32'hAABBCCDD);
    check("b2b_gap_ready", 32'(bus_a.word_ready), 32'd1);
    check("b2b_gap_we",    32'(bus_a.mem_we),     32'd0);
    tick();
    bus_a.word_valid = 1'b0;
    expect_bytes_a("b2b_w1", 16'h0004, 32'h01020304);
    check("b2b_done",  32'(bus_a.done),       32'd1);
    check("b2b_count", 32'(bus_a.word_count), 32'd2);
    check("b2b_writes", 32'(wr_a), 32'd12);

    // Clear versus transfer in the same cycle
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_a.word_valid = 1'b1; bus_a.word_data = 32'h10000000 + 32'(k); bus_a.word_last = 1'b0;
      wait_ready_a($sformatf("three_ready%0d", k));
      tick();
      bus_a.word_valid = 1'b0;
      expect_bytes_a($sformatf("three_w%0d", k), 16'(4 * k), 32'h10000000 + 32'(k));
    end
    check("three_count", 32'(bus_a.word_count), 32'd3);
    clear_a = 1'b1; bus_a.word_valid = 1'b1; bus_a.word_data = 32'hCAFEF00D; bus_a.word_last = 1'b0;
    tick();
    check("cvt_we",    32'(bus_a.mem_we),     32'd0);
    check("cvt_addr",  32'(bus_a.mem_addr),   32'd0);
    check("cvt_count", 32'(bus_a.word_count), 32'd0);
    check("cvt_ready", 32'(bus_a.word_ready), 32'd1);
    clear_a = 1'b0;
    tick();
    bus_a.word_valid = 1'b0;
    expect_bytes_a("cvt_word", 16'h0000, 32'hCAFEF00D);

    // Reset after the second byte of a word
    bus_a.word_valid = 1'b1; bus_a.word_data = 32'hDEADBEEF; bus_a.word_last = 1'b1;
    wait_ready_a("rmw_ready");
    wr0 = wr_a;
    tick();
    bus_a.word_valid = 1'b0;
    check("rmw_addr0", 32'(bus_a.mem_addr),  32'd4);
    check("rmw_data0", 32'(bus_a.mem_wdata), 32'hDE);
    tick();
    check("rmw_data1", 32'(bus_a.mem_wdata), 32'hAD);
    tick();
    rst_a = 1'b0;
    #1;
    check("rmw_we",    32'(bus_a.mem_we),     32'd0);
    check("rmw_addr",  32'(bus_a.mem_addr),   32'd0);
    check("rmw_wdata", 32'(bus_a.mem_wdata),  32'd0);
    check("rmw_ready", 32'(bus_a.word_ready), 32'd0);
    check("rmw_count", 32'(bus_a.word_count), 32'd0);
    check("rmw_done",  32'(bus_a.done),       32'd0);
    tick();
    check("rmw_nwrites", 32'(wr_a - wr0), 32'd2);
    check("rmw_mem4", 32'(mem_a[4]), 32'hDE);
    check("rmw_mem5", 32'(mem_a[5]), 32'hAD);
    check("rmw_mem6", 32'(mem_a[6]), 32'h00);
    rst_a = 1'b1;

    // Memory full with a 16-byte target, last never set
    bus_f.word_valid = 1'b1; bus_f.word_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_f.word_data = words_f[k];
      n = 0;
      while (!bus_f.word_ready && n < 20) begin tick(); n++; end
      check($sformatf("full_ready%0d", k), 32'(bus_f.word_ready), 32'd1);
      tick();
    end
    bus_f.word_data = 32'hFFFFFFFF;
    tick(); tick(); tick(); tick();
    check("full_done",   32'(bus_f.done),       32'd1);
    check("full_ptr",    32'(bus_f.mem_addr),   32'd0);
    check("full_count",  32'(bus_f.word_count), 32'd4);
    check("full_writes", 32'(wr_f), 32'd16);
    check("full_mem0",   32'(mem_f[0]),  32'h00);
    check("full_mem15",  32'(mem_f[15]), 32'h0F);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("full_hold_ready%0d", k), 32'(bus_f.word_ready), 32'd0);
      check($sformatf("full_hold_we%0d", k),    32'(bus_f.mem_we),     32'd0);
      tick();
    end
    check("full_hold_writes", 32'(wr_f), 32'd16);
    check("full_hold_mem0",   32'(mem_f[0]), 32'h00);
    bus_f.word_valid = 1'b0;

    // Non-zero base address
    bus_b.word_valid = 1'b1; bus_b.word_data = 32'h0A0B0C0D; bus_b.word_last = 1'b1;
    n = 0;
    while (!bus_b.word_ready && n < 20) begin tick(); n++; end
    check("base_ready", 32'(bus_b.word_ready), 32'd1);
    tick();
    bus_b.word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("base_addr%0d", i), 32'(bus_b.mem_addr),  32'h100 + 32'(i));
      check($sformatf("base_data%0d", i), 32'(bus_b.mem_wdata), 32'h0A + 32'(i));
      tick();
    end
    check("base_done",  32'(bus_b.done),       32'd1);
    check("base_count", 32'(bus_b.word_count), 32'd1);
    check("base_mem",   32'(mem_b[16'h103]),   32'h0D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instruction_memory_loader
